mersenne_wide_mult: RTL and testbench
=====================================

Name: mersenne_wide_mult

Overview:
Sequential shift-add multiplier that produces the 2P-bit product of two P-bit residues. It is the producer side of the Mersenne reducers, which consume a 2P-bit value and fold it to a P-bit residue. Output is valid/ready so it chains directly into the FSM reducer or the combinational reducer. A square mode supports Lucas-Lehmer style s*s iteration.

Parameters:
P, 13, Mersenne exponent and operand width.
WIDTH, 2*P, product width. Must equal 2*P.
EARLY_EXIT, 0, when 1, finish as soon as the remaining multiplier bits are zero.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
valid_in  in  1  operand request
ready_in  out  1  block can accept operands
a  in  P  multiplicand
b  in  P  multiplier, ignored when sq=1
sq  in  1  square mode: b is taken as a
product  out  WIDTH  a*b, unsigned and exact (no modular reduction)
valid_out  out  1  product valid
ready_out  in  1  downstream accepts product
busy  out  1  high in BUSY state

Behaviour:
- Reset (async, active-high): state=IDLE; acc, a_sh, b_sh, count=0; product=0; valid_out=0; busy=0. valid_in is ignored while rst is high. ready_in=(state==IDLE) and reads 1 once rst falls.
- Reset mid-operation aborts immediately. No product is emitted, and no partial state survives.
- States: IDLE, BUSY, DONE. State is registered; ready_in, busy and valid_out are decoded from state.
- IDLE:
  - Accept on any edge where valid_in && ready_in.
  - On accept, latch a_sh=zero-extend(a) to WIDTH, b_sh=(sq ? a : b), acc=0, count=0, then go to BUSY.
- BUSY, each edge:
  - if b_sh[0], acc += a_sh (WIDTH-bit add; cannot overflow because a,b < 2^P).
  - a_sh <<= 1; b_sh >>= 1; count++.
  - Go to DONE on the edge where count==P-1, or where EARLY_EXIT==1 and b_sh[P-1:1]==0.
- Latency: with EARLY_EXIT=0, valid_out rises exactly P edges after the accept edge. With EARLY_EXIT=1, it rises k edges after accept, where k = max(1, bit-length of the multiplier).
- DONE:
  - product = acc, valid_out = 1.
  - product and valid_out hold stable while ready_out=0 (unbounded backpressure).
  - On the edge with ready_out=1, go to IDLE and drop valid_out.
  - ready_in is 0 in DONE, so there is no overlap: max throughput is one product per P+2 cycles.
- valid_in is ignored in BUSY and DONE, and operands change freely there.
- Boundary values:
  - a=0 or b=0 gives product 0.
  - a=b=2^P-1 gives (2^P-1)^2, the maximal value, with no truncation.
  - Operands equal to M=2^P-1 are passed through unreduced. Reduction is the consumer's job.
- count width is clog2(P). count is not exported.

Decomposition:
- Shared package mersenne_pkg holds:
  - default P
  - WIDTH=2*P
  - MERSENNE=(1<<P)-1
  - state encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10, shared with the reducer FSM
- No sub-module. The adder, shifters and FSM are small enough to live inline.

Test Plan (P=13):
- EARLY_EXIT=0, a=3, b=5, sq=0 -> product=15; valid_out rises 13 edges after accept; ready_in=0 throughout.
- a=b=8191 -> product=67092481 (0x3FFC001). Feeding it to the comb reducer gives result 0.
- EARLY_EXIT=1, a=3, b=5 -> product=15 after 3 edges. With b=0, product=0 after 1 edge.
- sq=1, a=4, b=777 (ignored) -> product=16.
- Backpressure: hold ready_out=0 for 10 cycles in DONE -> product and valid_out stay stable; valid_in pulses are ignored; pulsing ready_out -> IDLE next edge, ready_in=1.
- Assert rst at the 5th BUSY cycle -> valid_out=0, product=0, state IDLE asynchronously; a new request after release gives the correct product.

Source files
------------

// File: rtl/mersenne_pkg.sv
// rtl/mersenne_pkg.sv - shared Mersenne parameters and FSM state encoding
package mersenne_pkg;

  localparam int P_DEFAULT     = 13;
  localparam int WIDTH_DEFAULT = 2 * P_DEFAULT;
  localparam logic [P_DEFAULT-1:0] MERSENNE = P_DEFAULT'((64'd1 << P_DEFAULT) - 64'd1);

  // Encoding is shared with the reducer FSM so state can be compared across blocks.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mersenne_wide_mult.sv
// rtl/mersenne_wide_mult.sv - sequential shift-add P x P -> 2P multiplier with valid/ready handshake
module mersenne_wide_mult
  import mersenne_pkg::*;
#(
  parameter int P          = P_DEFAULT,
  parameter int WIDTH      = 2 * P,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [P-1:0]     a,
  input  logic [P-1:0]     b,
  input  logic             sq,
  output logic [WIDTH-1:0] product,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             busy
);

  localparam int CW = (P > 1) ? $clog2(P) : 1;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_sh;
  logic [P-1:0]     b_sh;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] acc_next;
  logic             last_step;

  assign acc_next = b_sh[0] ? (acc + a_sh) : acc;

  // Early exit fires once no set multiplier bits remain above the one consumed this edge.
  assign last_step = (count == CW'(P - 1)) ||
                     ((EARLY_EXIT != 0) && ((b_sh >> 1) == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            a_sh  <= WIDTH'(a);
            b_sh  <= sq ? a : b;
            acc   <= '0;
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          a_sh  <= a_sh << 1;
          b_sh  <= b_sh >> 1;
          count <= count + 1'b1;
          if (last_step) begin
            product <= acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          if (ready_out) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_in  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign valid_out = (state == DONE);

endmodule

// File: tb/tb_mersenne_wide_mult.sv
// tb/tb_mersenne_wide_mult.sv - self-checking bench for mersenne_wide_mult (P=13, EARLY_EXIT 0 and 1)
module tb_mersenne_wide_mult;

  localparam int P = 13;
  localparam int W = 2 * P;

  logic         clk;
  logic         rst;
  logic [P-1:0] a;
  logic [P-1:0] b;
  logic         sq;
  logic         ready_out;
  logic         vin0, vin1;
  logic         rin0, rin1;
  logic         vout0, vout1;
  logic         busy0, busy1;
  logic [W-1:0] prod0, prod1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];

  mersenne_wide_mult #(.P(P), .WIDTH(W), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .valid_in(vin0), .ready_in(rin0), .a(a), .b(b), .sq(sq),
    .product(prod0), .valid_out(vout0), .ready_out(ready_out), .busy(busy0)
  );

  mersenne_wide_mult #(.P(P), .WIDTH(W), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(vin1), .ready_in(rin1), .a(a), .b(b), .sq(sq),
    .product(prod1), .valid_out(vout1), .ready_out(ready_out), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0] va;
    logic [P-1:0] vb;
    logic         vsq;
    logic [W-1:0] vprod;
  } vec_t;

  vec_t vecs[8];

  function automatic logic rin(input int d);
    return (d == 0) ? rin0 : rin1;
  endfunction

  function automatic logic vout(input int d);
    return (d == 0) ? vout0 : vout1;
  endfunction

  function automatic logic [W-1:0] prod(input int d);
    return (d == 0) ? prod0 : prod1;
  endfunction

  function automatic int bitlen(input logic [P-1:0] v);
    int n = 0;
    for (int i = 0; i < P; i++) if (v[i]) n = i + 1;
    return (n < 1) ? 1 : n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vin(input int d, input logic v);
    if (d == 0) vin0 = v; else vin1 = v;
  endtask

  task automatic do_op(input int d, input logic [P-1:0] ta, input logic [P-1:0] tb_v,
                       input logic tsq, input logic [W-1:0] expp, input int explat);
    int   lat;
    logic saw_ready;
    logic [W-1:0] exp_q;
    @(negedge clk);
    a = ta; b = tb_v; sq = tsq;
    set_vin(d, 1'b1);
    check("ready_in_idle", 64'(rin(d)), 64'd1);
    @(posedge clk); #1;
    set_vin(d, 1'b0);
    sb.push_back(expp);
    // scramble operands: the block must have latched them
    a = P'($urandom); b = P'($urandom); sq = 1'($urandom);
    lat = 0;
    saw_ready = 1'b0;
    while (!vout(d) && lat < 100) begin
      if (rin(d)) saw_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(explat));
    check("ready_in_low_busy", 64'(saw_ready), 64'd0);
    exp_q = sb.pop_front();
    check("product", 64'(prod(d)), 64'(exp_q));
    @(negedge clk);
    ready_out = 1'b1;
    @(posedge clk); #1;
    ready_out = 1'b0;
    check("ready_in_after", 64'(rin(d)), 64'd1);
    check("valid_out_after", 64'(vout(d)), 64'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    logic         stable;

    vecs[0] = '{13'd3,    13'd5,    1'b0, 26'd15};
    vecs[1] = '{13'd8191, 13'd8191, 1'b0, 26'd67092481};
    vecs[2] = '{13'd0,    13'd1234, 1'b0, 26'd0};
    vecs[3] = '{13'd3,    13'd0,    1'b0, 26'd0};
    vecs[4] = '{13'd4,    13'd777,  1'b1, 26'd16};
    vecs[5] = '{13'd1,    13'd8191, 1'b0, 26'd8191};
    vecs[6] = '{13'd100,  13'd200,  1'b0, 26'd20000};
    vecs[7] = '{13'd4096, 13'd4096, 1'b0, 26'd16777216};

    rst = 1'b1; a = '0; b = '0; sq = 1'b0; ready_out = 1'b0; vin0 = 1'b1; vin1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_out0", 64'(vout0), 64'd0);
    check("reset_busy0", 64'(busy0), 64'd0);
    @(negedge clk);
    vin0 = 1'b0; vin1 = 1'b0;
    rst = 1'b0;
    #1;
    check("reset_ready_in0", 64'(rin0), 64'd1);
    check("reset_ready_in1", 64'(rin1), 64'd1);
    check("reset_product0", 64'(prod0), 64'd0);
    check("reset_product1", 64'(prod1), 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_op(0, vecs[i].va, vecs[i].vb, vecs[i].vsq, vecs[i].vprod, P);
      do_op(1, vecs[i].va, vecs[i].vb, vecs[i].vsq, vecs[i].vprod,
            bitlen(vecs[i].vsq ? vecs[i].va : vecs[i].vb));
    end

    // backpressure: hold DONE for 10 cycles with valid_in pulses
    @(negedge clk);
    a = 13'd7; b = 13'd9; sq = 1'b0; vin0 = 1'b1;
    @(posedge clk); #1;
    vin0 = 1'b0;
    repeat (P) @(posedge clk);
    #1;
    check("bp_valid_rise", 64'(vout0), 64'd1);
    held = prod0;
    check("bp_product", 64'(held), 64'd63);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vin0 = c[0];
      a = P'($urandom); b = P'($urandom);
      @(posedge clk); #1;
      if (!vout0 || prod0 !== held || rin0) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    @(negedge clk);
    vin0 = 1'b0; ready_out = 1'b1;
    @(posedge clk); #1;
    ready_out = 1'b0;
    check("bp_release_ready_in", 64'(rin0), 64'd1);
    check("bp_release_valid_out", 64'(vout0), 64'd0);
    @(posedge clk); #1;
    check("bp_no_spurious_accept", 64'(busy0), 64'd0);

    // asynchronous reset during the 5th BUSY cycle
    @(negedge clk);
    a = 13'd123; b = 13'd456; sq = 1'b0; vin0 = 1'b1;
    @(posedge clk); #1;
    vin0 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy", 64'(busy0), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy0), 64'd0);
    check("async_rst_valid_out", 64'(vout0), 64'd0);
    check("async_rst_product", 64'(prod0), 64'd0);
    check("async_rst_ready_in", 64'(rin0), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (P + 2) @(posedge clk);
    #1;
    check("no_product_after_abort", 64'(vout0), 64'd0);
    do_op(0, 13'd123, 13'd456, 1'b0, 26'd56088, P);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
